// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg -- shared encodings for the RV32I program-counter unit.
//   NPC_*      : next-PC select codes driven by the decoder (100-111 act as NPC_SEQ).
//   pcu_state_e: pc_unit FSM states (RUN / TRAP / HALT).
package pc_unit_pkg;

  localparam logic [2:0] NPC_SEQ    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JAL    = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b011;

  typedef enum logic [1:0] {
    PCU_RUN  = 2'd0,
    PCU_TRAP = 2'd1,
    PCU_HALT = 2'd2
  } pcu_state_e;

endpackage

// File: rtl/pc_unit_npc.sv
// npc_calc -- purely combinational next-PC target select for pc_unit.
// Ports:
//   pc        in  32 : current architectural PC
//   npc_op    in  3  : next-PC select (NPC_*)
//   imm       in  32 : sign-extended B/J immediate
//   alu_c     in  32 : ALU result (jalr target before bit-0 clear)
//   alu_zero  in  1  : ALU zero flag, doubles as branch-taken
//   stall     in  1  : pipeline stall, suppresses redirect
//   hold      in  1  : unit is halted, suppresses redirect
//   pc_plus4  out 32 : pc+4 link value
//   npc       out 32 : selected next PC
//   redirect  out 1  : a non-sequential target is taken this cycle
//   misalign  out 1  : redirecting target not word aligned
//                      (port present only with PC_MISALIGN_TRAP_EN)
module npc_calc
  import pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  input  logic        stall,
  input  logic        hold,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        redirect
);

  logic [31:0] target;
  logic        jump;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    target   = pc_plus4;
    jump     = 1'b0;
    case (npc_op)
      NPC_BRANCH: begin
        // ALU branch ops yield zero exactly when the branch is taken.
        if (alu_zero) begin
          target = pc + imm;
          jump   = 1'b1;
        end
      end
      NPC_JAL: begin
        target = pc + imm;
        jump   = 1'b1;
      end
      NPC_JALR: begin
        target = alu_c & 32'hFFFF_FFFE;
        jump   = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign npc      = target;
  assign misalign = jump & (target[1:0] != 2'b00);
`else
  // Without the trap, low bits are simply dropped so pc stays word aligned.
  assign npc      = target & 32'hFFFF_FFFC;
`endif

  assign redirect = jump & ~stall & ~hold;

endmodule

// File: rtl/pc_unit.sv
// pc_unit -- architectural PC register, RUN/TRAP/HALT FSM and retired-
// instruction counter for the single-cycle RV32I core.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> trap).
// Parameters: RESET_PC (PC after reset), TRAP_VEC (PC on misaligned trap).
// Ports:
//   clk       in  1  : clock, rising edge
//   rstn      in  1  : synchronous active-low reset
//   stall     in  1  : hold PC, no retire
//   halt_req  in  1  : ecall/ebreak, enter HALT
//   npc_op    in  3  : next-PC select (NPC_*)
//   imm       in  32 : sign-extended immediate
//   alu_c     in  32 : ALU result
//   alu_zero  in  1  : ALU zero flag
//   pc        out 32 : registered PC
//   pc_plus4  out 32 : pc+4 (combinational)
//   npc       out 32 : next PC (combinational)
//   redirect  out 1  : non-sequential target taken (combinational)
//   halted    out 1  : state is HALT
//   trap      out 1  : state is TRAP
//   epc       out 32 : faulting PC
//   instret   out 32 : retired-instruction count
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        halt_req,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc,
  output logic        redirect,
  output logic        halted,
  output logic        trap,
  output logic [31:0] epc,
  output logic [31:0] instret
);

  pcu_state_e  state;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        halted_q;
  logic        trap_take;

  npc_calc u_npc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .imm      (imm),
    .alu_c    (alu_c),
    .alu_zero (alu_zero),
    .stall    (stall),
    .hold     (state == PCU_HALT),
    .pc_plus4 (pc_plus4),
    .npc      (npc),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign (trap_take),
`endif
    .redirect (redirect)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] epc_q;
  assign trap = trap_q;
  assign epc  = epc_q;
`else
  // TRAP is unreachable in this build; the trap path folds away.
  assign trap_take = 1'b0;
  assign trap      = 1'b0;
  assign epc       = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q      <= RESET_PC;
      state     <= PCU_RUN;
      instret_q <= '0;
      halted_q  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
      epc_q     <= '0;
`endif
    end else if (state == PCU_HALT) begin
      // terminal: only reset leaves HALT
    end else if (stall) begin
      // everything holds, including a pending TRAP marker
    end else if (halt_req) begin
      state     <= PCU_HALT;
      halted_q  <= 1'b1;
      instret_q <= instret_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else if (trap_take) begin
      pc_q      <= TRAP_VEC;
      state     <= PCU_TRAP;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b1;
      epc_q     <= pc_q;
`endif
    end else begin
      pc_q      <= npc;
      state     <= PCU_RUN;
      instret_q <= instret_q + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end
  end

  assign pc      = pc_q;
  assign instret = instret_q;
  assign halted  = halted_q;

endmodule
